// File: rtl/disp99_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : disp99_arbiter_if
// Description : Requester / decoder-side bundle for the shared 0-99 display
//               arbiter. The master side drives the requests and the values.
//               The slave side (the arbiter) drives the decoder value and
//               strobe, and returns grant/ack/busy.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp99_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] value_flat;
  logic [7:0]         data_out;
  logic               sig_out;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   ack;
  logic               busy;

  modport master (
    output req, value_flat,
    input  data_out, sig_out, grant, ack, busy
  );

  modport slave (
    input  req, value_flat,
    output data_out, sig_out, grant, ack, busy
  );
endinterface
`default_nettype wire

// File: rtl/disp99_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp99_arbiter
// Description : Round-robin scheduler that shares one two-digit seven-segment
//               decoder between up to four requesters. Each winner owns the
//               display for HOLD_CYCLES cycles. Values above 99 show as
//               blank (100). The display is also blank while idle.
//               Optional macro DISP99_ARB_LIVE_EN: the owner's value is
//               re-sampled every cycle of the slot, and the strobe pulses on
//               every value change.
// Revision    : 1.0 - initial release
// ============================================================================
module disp99_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  disp99_arbiter_if.slave bus
);

  localparam int               PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]       C_BLANK    = 8'd100;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] C_PTR_RST  = PTR_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [PTR_W-1:0]   r_ptr, w_ptr;
  logic [N_REQ-1:0]   r_grant, w_grant;
  logic [N_REQ-1:0]   r_ack, w_ack;
  logic [7:0]         r_data, w_data;
  logic               r_sig, w_sig;
  logic               r_busy;

  logic               w_arb;
  logic               w_win_vld;
  logic [PTR_W-1:0]   w_win_idx;
  logic [PTR_W-1:0]   w_scan_idx;
  int                 w_scan;
  logic [7:0]         w_val_san [N_REQ];

  function automatic logic [7:0] sanitise(input logic [7:0] v);
    return (v > 8'd99) ? C_BLANK : v;
  endfunction

  // Per-requester values, already clamped to the decoder's legal range
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_val
      assign w_val_san[gi] = sanitise(bus.value_flat[8*gi +: 8]);
    end
  endgenerate

  // Round-robin search: the first set request after the pointer, wrapping
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = '0;
    w_scan     = 0;
    w_scan_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_scan = int'(r_ptr) + off;
      if (w_scan >= N_REQ) begin
        w_scan = w_scan - N_REQ;
      end
      w_scan_idx = PTR_W'(w_scan);
      if (!w_win_vld && bus.req[w_scan_idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_scan_idx;
      end
    end
  end

  // Next-state logic. While in SHOW the pointer doubles as the owner index.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_ptr   = r_ptr;
    w_grant = r_grant;
    w_data  = r_data;
    w_sig   = 1'b0;
    w_ack   = '0;
    w_arb   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arb = 1'b1;
      end
      ST_SHOW: begin
        if ((bus.req & r_grant) == '0) begin
          // Owner let go early: the slot ends without an acknowledge
          w_arb = 1'b1;
        end else if (r_cnt == '0) begin
          w_ack = r_grant;
          w_arb = 1'b1;
        end else begin
          w_cnt = r_cnt - 1'b1;
`ifdef DISP99_ARB_LIVE_EN
          w_data = w_val_san[r_ptr];
          w_sig  = (w_val_san[r_ptr] != r_data);
`endif
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    if (w_arb) begin
      if (w_win_vld) begin
        w_state            = ST_SHOW;
        w_grant            = '0;
        w_grant[w_win_idx] = 1'b1;
        w_ptr              = w_win_idx;
        w_cnt              = C_CNT_LOAD;
        w_data             = w_val_san[w_win_idx];
        w_sig              = 1'b1;
      end else begin
        w_state = ST_IDLE;
        w_grant = '0;
        w_cnt   = '0;
        w_data  = C_BLANK;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= C_PTR_RST;
      r_grant <= '0;
      r_ack   <= '0;
      r_data  <= C_BLANK;
      r_sig   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
      r_grant <= w_grant;
      r_ack   <= w_ack;
      r_data  <= w_data;
      r_sig   <= w_sig;
      r_busy  <= |w_grant;
    end
  end

  assign bus.data_out = r_data;
  assign bus.sig_out  = r_sig;
  assign bus.grant    = r_grant;
  assign bus.ack      = r_ack;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_disp99_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp99_arbiter
// Description : Self-checking bench for disp99_arbiter (N_REQ=4,
//               HOLD_CYCLES=4). Each expected grant (owner, shown value) is
//               queued when stimulus is applied. It is popped when the DUT
//               strobes a new grant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp99_arbiter;

  localparam int N_REQ = 4;
  localparam int HOLD  = 4;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] v;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp99_arbiter_if #(.N_REQ(N_REQ)) bus ();

  disp99_arbiter #(
    .N_REQ       (N_REQ),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [3:0] prev_grant = '0;
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         vals[4]    = '{5, 17, 63, 99};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int v);
    exp_t e;
    e.g = 4'(1 << idx);
    e.v = 8'(v);
    sb_q.push_back(e);
  endtask

  task automatic set_val(input int idx, input int v);
    bus.value_flat[8*idx +: 8] = 8'(v);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_data"},  32'(bus.data_out), 32'(100));
    check({tag, "_sig"},   32'(bus.sig_out),  32'(0));
    check({tag, "_grant"}, 32'(bus.grant),    32'(0));
    check({tag, "_ack"},   32'(bus.ack),      32'(0));
    check({tag, "_busy"},  32'(bus.busy),     32'(0));
  endtask

  // Scoreboard: a new grant is a strobe with a changed owner or a completed slot
  always @(posedge clk) begin
    #2;
    if (bus.sig_out && bus.grant != 4'd0 && (bus.grant != prev_grant || bus.ack != 4'd0)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_grant", 32'(bus.grant), 32'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_grant", 32'(bus.grant),    32'(mon_e.g));
        check("sb_data",  32'(bus.data_out), 32'(mon_e.v));
      end
    end
    prev_grant = bus.grant;
  end

  initial begin
    bus.req        = '0;
    bus.value_flat = '0;
    rst_n          = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("idle_data", 32'(bus.data_out), 32'(100));
      check("idle_busy", 32'(bus.busy),     32'(0));
    end

    // Single requester: grant, full dwell, then re-grant to the same owner
    set_val(0, 42);
    bus.req = 4'b0001;
    push(0, 42);
    tick();
    check("single_grant", 32'(bus.grant),    32'(1));
    check("single_data",  32'(bus.data_out), 32'(42));
    check("single_sig",   32'(bus.sig_out),  32'(1));
    check("single_busy",  32'(bus.busy),     32'(1));
    repeat (HOLD - 1) begin
      tick();
      check("single_hold_grant", 32'(bus.grant),   32'(1));
      check("single_hold_sig",   32'(bus.sig_out), 32'(0));
      check("single_hold_ack",   32'(bus.ack),     32'(0));
    end
    push(0, 42);
    tick();
    check("regrant_ack",   32'(bus.ack),      32'(1));
    check("regrant_grant", 32'(bus.grant),    32'(1));
    check("regrant_sig",   32'(bus.sig_out),  32'(1));
    check("regrant_data",  32'(bus.data_out), 32'(42));
    bus.req = 4'b0000;
    tick();
    check("drop0_grant", 32'(bus.grant),    32'(0));
    check("drop0_ack",   32'(bus.ack),      32'(0));
    check("drop0_data",  32'(bus.data_out), 32'(100));
    check("drop0_busy",  32'(bus.busy),     32'(0));

    // Asynchronous reset in the middle of a slot
    bus.req = 4'b0001;
    push(0, 42);
    tick();
    tick();
    check("pre_rst_grant", 32'(bus.grant), 32'(1));
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    bus.req = 4'b0000;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_data", 32'(bus.data_out), 32'(100));
    check("post_rst_busy", 32'(bus.busy),     32'(0));

    // Rotation over all four requesters, wrapping back to requester 0
    for (int i = 0; i < 4; i++) set_val(i, vals[i]);
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) push(i, vals[i]);
    push(0, vals[0]);
    tick();
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < HOLD; c++) begin
        check("rot_grant", 32'(bus.grant),    32'(1 << (s % 4)));
        check("rot_data",  32'(bus.data_out), 32'(vals[s % 4]));
        check("rot_busy",  32'(bus.busy),     32'(1));
        if (c == 0) begin
          check("rot_sig", 32'(bus.sig_out), 32'(1));
          check("rot_ack", 32'(bus.ack), (s == 0) ? 32'(0) : 32'(1 << ((s + 3) % 4)));
        end else begin
          check("rot_sig", 32'(bus.sig_out), 32'(0));
        end
        if (s == 4 && c == 0) begin
          bus.req = 4'b0101;
          push(2, vals[2]);
        end
        tick();
      end
    end

    // Early drop by requester 2 after two owned cycles
    check("ed_grant", 32'(bus.grant),    32'(4));
    check("ed_ack",   32'(bus.ack),      32'(1));
    check("ed_data",  32'(bus.data_out), 32'(63));
    tick();
    check("ed_hold", 32'(bus.grant), 32'(4));
    bus.req = 4'b0001;
    push(0, vals[0]);
    tick();
    check("ed_next_grant", 32'(bus.grant),    32'(1));
    check("ed_next_ack",   32'(bus.ack),      32'(0));
    check("ed_next_sig",   32'(bus.sig_out),  32'(1));
    check("ed_next_data",  32'(bus.data_out), 32'(5));
    bus.req = 4'b0000;
    tick();
    check("ed_idle_grant", 32'(bus.grant),    32'(0));
    check("ed_idle_ack",   32'(bus.ack),      32'(0));
    check("ed_idle_data",  32'(bus.data_out), 32'(100));

    // Out-of-range value blanks; pointer at 1 serves requester 3 before 0
    set_val(1, 150);
    bus.req = 4'b0010;
    push(1, 100);
    tick();
    check("san_grant", 32'(bus.grant),    32'(2));
    check("san_data",  32'(bus.data_out), 32'(100));
    check("san_busy",  32'(bus.busy),     32'(1));
    bus.req = 4'b1001;
    push(3, vals[3]);
    push(0, vals[0]);
    tick();
    check("wrap_grant3", 32'(bus.grant),    32'(8));
    check("wrap_ack",    32'(bus.ack),      32'(0));
    check("wrap_data3",  32'(bus.data_out), 32'(99));
    repeat (HOLD - 1) tick();
    tick();
    check("wrap_grant0", 32'(bus.grant),    32'(1));
    check("wrap_ack3",   32'(bus.ack),      32'(8));
    check("wrap_data0",  32'(bus.data_out), 32'(5));
    bus.req = 4'b0000;
    tick();
    check("wrap_idle_data", 32'(bus.data_out), 32'(100));

    // Owner value changes mid-slot
    set_val(0, 10);
    bus.req = 4'b0001;
    push(0, 10);
    tick();
    check("live_start", 32'(bus.data_out), 32'(10));
    tick();
    check("live_pre_data", 32'(bus.data_out), 32'(10));
    check("live_pre_sig",  32'(bus.sig_out),  32'(0));
    set_val(0, 11);
    tick();
`ifdef DISP99_ARB_LIVE_EN
    check("live_chg_data", 32'(bus.data_out), 32'(11));
    check("live_chg_sig",  32'(bus.sig_out),  32'(1));
`else
    check("live_chg_data", 32'(bus.data_out), 32'(10));
    check("live_chg_sig",  32'(bus.sig_out),  32'(0));
`endif
    check("live_chg_grant", 32'(bus.grant), 32'(1));
    bus.req = 4'b0000;
    tick();
    check("live_end_grant", 32'(bus.grant),    32'(0));
    check("live_end_data",  32'(bus.data_out), 32'(100));

    tick();
    check("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp99_arbiter.md
# disp99_arbiter

Round-robin scheduler sharing the single two-digit 0–99 seven-segment decoder between up to four requesters, e.g. two player scores, a timer and a status code. Each granted requester owns the display for a fixed dwell time, then the grant rotates. The block drives the decoder's 8-bit value input and its strobe input. It forces the blank code 100 when no requester is active.

## Interface
- `N_REQ`, default 4: number of requesters, legal 1..4.
- `HOLD_CYCLES`, default 50_000_000: dwell per grant in clock cycles, ≥2.
- `CNT_W`, default 26: dwell counter width; must hold `HOLD_CYCLES-1`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: level request per requester.
- `value_flat` in `8*N_REQ`: requester i value on bits `[8i+7:8i]`.
- `data_out` out 8: value to decoder, 0..99 or 100 (blank).
- `sig_out` out 1: one-cycle strobe on each new grant (decoder strobe input).
- `grant` out `N_REQ`: one-hot owner of display; all-zero when idle.
- `ack` out `N_REQ`: one-cycle pulse to requester whose full dwell completed.
- `busy` out 1: high while any grant active.

## Operation
- All outputs are registered.
- Reset values: `data_out`=100, `sig_out`=0, `grant`=0, `ack`=0, `busy`=0, dwell counter=0, RR pointer=`N_REQ-1`, state IDLE.
- State IDLE: `data_out`=100, `grant`=0.
  - Any `req` bit high → arbitrate, enter SHOW.
- Arbitration: search from pointer+1 upward, wrapping modulo `N_REQ`. The first set `req` bit wins. The pointer updates to the winner.
  - From reset, requester 0 has first priority.
- On grant: set `grant` one-hot, `sig_out`=1 for one cycle, counter=`HOLD_CYCLES-1`, and latch the winner's value into `data_out`.
- Value sanitising: any value >99 is output as 100 (blank).
- State SHOW: the counter decrements each cycle. At counter=0:
  - pulse `ack` for the owner;
  - if any `req` is high, re-arbitrate in the same edge, with no gap. The same requester may win again if it is the only one requesting, and `sig_out` pulses again.
  - otherwise go to IDLE.
- Early release: owner's `req` low while in SHOW → next edge the grant ends without `ack`, and arbitration runs the same as at slot end.
- Requests arriving mid-slot wait; they never pre-empt.
- Asynchronous reset mid-slot returns every register to its reset value immediately.

## Timing
- Grant latency: `req` high before edge k → `grant`, `data_out` and `sig_out` valid after edge k (1 cycle).
- Full slot: `grant` high exactly `HOLD_CYCLES` cycles.
  - `ack` is high in the cycle after the last owned cycle, concurrent with the next owner's first cycle.
- Back-to-back grants have zero idle cycles between them.
- `busy` equals the OR of `grant`.

## Configuration
- `DISP99_ARB_LIVE_EN` defined: while in SHOW, `data_out` re-samples the owner's sanitised value every cycle. `sig_out` pulses on the grant edge and on any cycle where the value changes.
- Not defined: `data_out` holds the value latched at grant for the whole slot, and `sig_out` pulses only on grant edges.

## Test plan
Bench uses `HOLD_CYCLES`=4 and `N_REQ`=4.

- Reset check: assert `rst_n`=0 mid-slot → all outputs at reset values in the same cycle. Release reset, `req`=0 → `data_out`=100 indefinitely, `busy`=0.
- Single requester, arbitration and re-grant: `req`=4'b0001, value0=42.
  - 1 cycle later: `grant`=0001, `data_out`=42, `sig_out` pulse.
  - `grant` held 4 cycles, then `ack`=0001 plus re-grant with a `sig_out` pulse.
- Rotation: all four requesting with values 5, 17, 63, 99.
  - Grants appear in order 0, 1, 2, 3, 0, each for 4 cycles.
  - `data_out` steps 5, 17, 63, 99, with no blank cycles.
- Early drop: requester 2 granted, `req[2]` falls after 2 cycles.
  - Next edge: `grant[2]`=0, no `ack`.
  - The next pending requester is granted, or the block returns to IDLE with `data_out`=100.
- Sanitise and wrap: value1=150 with `req`=0010 → `data_out`=100.
  - Then `req`=1001 with pointer at 1 → requester 3 is served before requester 0.
- Live update (with `DISP99_ARB_LIVE_EN` only): owner's value changes 10→11 mid-slot.
  - `data_out`=11 the next cycle, with a `sig_out` pulse.
  - Without the macro, `data_out` stays 10 until the slot ends.
